// File: rtl/uart_cmd_responder.sv
// Register-command responder: decodes 'W'/'R' packets from UART bytes, drives a simple register bus
// and paces one response byte per packet. Optional macro UART_CMD_CSUM_EN adds a trailing XOR checksum byte.
module uart_cmd_responder #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TX_GAP_CYC  = 11000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    input  logic [7:0]        i_reg_rdata,
    output logic              o_busy,
    output logic              o_drop
);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_UNK = 8'h3F;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(TX_GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_EXEC,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND
`ifdef UART_CMD_CSUM_EN
        , S_GET_CSUM
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_is_wr, w_is_wr_nxt;
    logic              r_addr_err, w_addr_err_nxt;
    logic [7:0]        r_resp, w_resp_nxt;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nxt;
    logic [7:0]        r_reg_wdata, w_reg_wdata_nxt;
    logic [7:0]        r_tx_hold;
    logic [GAP_W-1:0]  r_gap;
    logic [TO_W-1:0]   r_to_cnt;
    logic              w_fire;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_addr_bad;
`ifdef UART_CMD_CSUM_EN
    logic [7:0]        r_csum, w_csum_nxt;
`endif

    assign w_fire     = (r_state == S_SEND) && (r_gap == '0);
    assign w_addr_bad = (i_rx_data >> ADDR_W) != 8'd0;
`ifdef UART_CMD_CSUM_EN
    assign w_waiting  = r_state inside {S_GET_ADDR, S_GET_DATA, S_GET_CSUM};
`else
    assign w_waiting  = r_state inside {S_GET_ADDR, S_GET_DATA};
`endif
    assign w_timeout  = w_waiting && !i_rx_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    assign o_tx_valid  = w_fire;
    assign o_tx_data   = w_fire ? r_resp : r_tx_hold;
    assign o_reg_wr    = (r_state == S_EXEC);
    assign o_reg_rd    = (r_state == S_RD_REQ);
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_busy      = (r_state != S_IDLE);
    assign o_drop      = i_rx_valid && (r_state inside {S_EXEC, S_RD_REQ, S_RD_WAIT, S_SEND});

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_is_wr     <= 1'b0;
            r_addr_err  <= 1'b0;
            r_resp      <= 8'd0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 8'd0;
            r_tx_hold   <= 8'd0;
`ifdef UART_CMD_CSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_addr_err  <= w_addr_err_nxt;
            r_resp      <= w_resp_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            if (w_fire) begin
                r_tx_hold <= r_resp;
            end
`ifdef UART_CMD_CSUM_EN
            r_csum      <= w_csum_nxt;
`endif
        end
    end

    // Gap counter runs freely so packet reception overlaps the pacing wait.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_gap    <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_fire) begin
                r_gap <= GAP_W'(TX_GAP_CYC - 1);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (w_waiting && !i_rx_valid) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_is_wr_nxt     = r_is_wr;
        w_addr_err_nxt  = r_addr_err;
        w_resp_nxt      = r_resp;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
`ifdef UART_CMD_CSUM_EN
        w_csum_nxt      = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
`ifdef UART_CMD_CSUM_EN
                    w_csum_nxt = i_rx_data;
`endif
                    if (i_rx_data == CMD_WR) begin
                        w_is_wr_nxt = 1'b1;
                        w_state_nxt = S_GET_ADDR;
                    end else if (i_rx_data == CMD_RD) begin
                        w_is_wr_nxt = 1'b0;
                        w_state_nxt = S_GET_ADDR;
                    end else begin
                        w_resp_nxt  = RSP_UNK;
                        w_state_nxt = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_rx_valid) begin
                    w_reg_addr_nxt = i_rx_data[ADDR_W-1:0];
                    w_addr_err_nxt = w_addr_bad;
`ifdef UART_CMD_CSUM_EN
                    w_csum_nxt     = r_csum ^ i_rx_data;
`endif
                    if (r_is_wr) begin
                        w_state_nxt = S_GET_DATA;
                    end else begin
`ifdef UART_CMD_CSUM_EN
                        w_state_nxt = S_GET_CSUM;
`else
                        if (w_addr_bad) begin
                            w_resp_nxt  = RSP_ERR;
                            w_state_nxt = S_SEND;
                        end else begin
                            w_state_nxt = S_RD_REQ;
                        end
`endif
                    end
                end
            end
            S_GET_DATA: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_rx_valid) begin
                    w_reg_wdata_nxt = i_rx_data;
`ifdef UART_CMD_CSUM_EN
                    w_csum_nxt      = r_csum ^ i_rx_data;
                    w_state_nxt     = S_GET_CSUM;
`else
                    if (r_addr_err) begin
                        w_resp_nxt  = RSP_ERR;
                        w_state_nxt = S_SEND;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
`endif
                end
            end
`ifdef UART_CMD_CSUM_EN
            // A bad checksum outranks a bad address; both suppress the register access.
            S_GET_CSUM: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (i_rx_valid) begin
                    if ((i_rx_data != r_csum) || r_addr_err) begin
                        w_resp_nxt  = RSP_ERR;
                        w_state_nxt = S_SEND;
                    end else if (r_is_wr) begin
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_RD_REQ;
                    end
                end
            end
`endif
            S_EXEC: begin
                w_resp_nxt  = RSP_OK;
                w_state_nxt = S_SEND;
            end
            S_RD_REQ: begin
                w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_resp_nxt  = i_reg_rdata;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Self-checking bench for uart_cmd_responder: packet-level response/access model plus directed
// latency, pacing, timeout, drop and reset checks. Honours UART_CMD_CSUM_EN when defined.
module tb_uart_cmd_responder;

    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 100;
    localparam int TX_GAP_CYC  = 50;

    typedef struct {
        bit         isWr;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic              rxValid = 1'b0;
    logic [7:0]        rxData = 8'd0;
    logic              txValid;
    logic [7:0]        txData;
    logic              regWr;
    logic              regRd;
    logic [ADDR_W-1:0] regAddr;
    logic [7:0]        regWdata;
    logic [7:0]        regRdata = 8'hEE;
    logic              busy;
    logic              drop;

    int nCompared = 0;
    int nMismatch = 0;
    int cyc = 0;
    int rxCyc = 0, wrCyc = 0, rdCyc = 0, txCyc = 0;
    int lastTxCyc = -100000;
    int wrCount = 0, rdCount = 0, txCount = 0, dropCount = 0, expDrops = 0;
    logic [7:0] lastTxData = 8'd0;
    logic [7:0] lastWrData = 8'd0;
    logic [ADDR_W-1:0] lastWrAddr = '0;
    acc_t expAcc[$];
    logic [7:0] expResp[$];

    uart_cmd_responder #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TX_GAP_CYC(TX_GAP_CYC)
    ) dut (
        .i_clk(clk),
        .i_rst(rstN),
        .i_rx_valid(rxValid),
        .i_rx_data(rxData),
        .o_tx_valid(txValid),
        .o_tx_data(txData),
        .o_reg_wr(regWr),
        .o_reg_rd(regRd),
        .o_reg_addr(regAddr),
        .o_reg_wdata(regWdata),
        .i_reg_rdata(regRdata),
        .o_busy(busy),
        .o_drop(drop)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] romByte(input logic [ADDR_W-1:0] a);
        return (a == 4'd3) ? 8'h5C : (8'h80 + {4'h0, a});
    endfunction

    // Register device: read data is valid only in the cycle after the read strobe.
    always @(posedge clk) regRdata <= regRd ? romByte(regAddr) : 8'hEE;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk);
        #1;
        rxValid = 1'b1;
        rxData  = b;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    // Packet-level model: what one complete packet must produce on the bus and on TX.
    task automatic expectPacket(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [7:0] data, input logic [7:0] cs);
        acc_t a;
        if (cmd != 8'h57 && cmd != 8'h52) begin
            expResp.push_back(8'h3F);
            return;
        end
`ifdef UART_CMD_CSUM_EN
        if (cs != ((cmd == 8'h57) ? (cmd ^ addr ^ data) : (cmd ^ addr))) begin
            expResp.push_back(8'h45);
            return;
        end
`endif
        if (int'(addr) >= (1 << ADDR_W)) begin
            expResp.push_back(8'h45);
            return;
        end
        a.isWr = (cmd == 8'h57);
        a.addr = addr;
        a.data = data;
        expAcc.push_back(a);
        expResp.push_back(a.isWr ? 8'h4B : romByte(addr[ADDR_W-1:0]));
    endtask

    task automatic sendPacket(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                              input bit forceCs, input logic [7:0] csVal);
        logic [7:0] cs;
        cs = (cmd == 8'h57) ? (cmd ^ addr ^ data) : (cmd ^ addr);
        if (forceCs) cs = csVal;
        expectPacket(cmd, addr, data, cs);
        applyStimulus(cmd);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            applyStimulus(addr);
            if (cmd == 8'h57) applyStimulus(data);
`ifdef UART_CMD_CSUM_EN
            applyStimulus(cs);
`endif
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idleBound", 32'(busy), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: every bus access and TX byte is matched against the model queues.
    always @(negedge clk) begin
        acc_t a;
        cyc++;
        if (!rstN) begin
            lastTxCyc  = -100000;
            lastTxData = 8'd0;
        end else begin
            if (rxValid) rxCyc = cyc;
            if (regWr && regRd) checkOutput("wrRdExclusive", 32'd1, 32'd0);
            if (regWr || regRd) begin
                if (expAcc.size() == 0) begin
                    checkOutput("unexpectedAccess", 32'({regWr, regRd}), 32'd0);
                end else begin
                    a = expAcc.pop_front();
                    checkOutput("accKind", 32'(regWr), 32'(a.isWr));
                    checkOutput("accAddr", 32'(regAddr), 32'(a.addr));
                    if (a.isWr) checkOutput("accData", 32'(regWdata), 32'(a.data));
                end
                if (regWr) begin
                    wrCyc = cyc; wrCount++; lastWrAddr = regAddr; lastWrData = regWdata;
                end else begin
                    rdCyc = cyc; rdCount++;
                end
            end
            if (txValid) begin
                checkOutput("txGap", (cyc - lastTxCyc >= TX_GAP_CYC) ? 32'd1 : 32'd0, 32'd1);
                if (expResp.size() == 0) checkOutput("unexpectedTx", 32'd1, 32'd0);
                else checkOutput("txData", 32'(txData), 32'(expResp.pop_front()));
                lastTxCyc = cyc; txCyc = cyc; txCount++; lastTxData = txData;
            end else begin
                checkOutput("txHold", 32'(txData), 32'(lastTxData));
            end
            if (drop) dropCount++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int prevTx, wr0, rd0, tx0;
        idleCycles(3);
        checkOutput("resetOutputs",
            32'({txValid, txData, regWr, regRd, regAddr, regWdata, busy, drop}), 32'd0);
        rstN = 1'b1;
        idleCycles(3);
        checkOutput("idleAfterReset", 32'(busy), 32'd0);

        $display("[TB] write W 03 A5");
        sendPacket(8'h57, 8'h03, 8'hA5, 1'b0, 8'h00);
        waitIdle();
        checkOutput("wrLatency", 32'(wrCyc - rxCyc), 32'd1);
        checkOutput("wrRespLatency", 32'(txCyc - rxCyc), 32'd2);
        checkOutput("wrResp", 32'(lastTxData), 32'h4B);
        checkOutput("wrAddr", 32'(lastWrAddr), 32'd3);
        checkOutput("wrData", 32'(lastWrData), 32'hA5);
        checkOutput("addrHeld", 32'(regAddr), 32'd3);
        idleCycles(60);

        $display("[TB] read R 03");
        sendPacket(8'h52, 8'h03, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("rdLatency", 32'(rdCyc - rxCyc), 32'd1);
        checkOutput("rdRespLatency", 32'(txCyc - rxCyc), 32'd3);
        checkOutput("rdResp", 32'(lastTxData), 32'h5C);
        idleCycles(60);

        $display("[TB] error packets");
        sendPacket(8'h41, 8'h00, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("unknownResp", 32'(lastTxData), 32'h3F);
        idleCycles(60);
        rd0 = rdCount;
        sendPacket(8'h52, 8'h20, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("rdAddrErrResp", 32'(lastTxData), 32'h45);
        checkOutput("rdAddrErrNoRd", 32'(rdCount - rd0), 32'd0);
        idleCycles(60);
        wr0 = wrCount;
        sendPacket(8'h57, 8'h10, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("wrAddrErrResp", 32'(lastTxData), 32'h45);
        checkOutput("wrAddrErrNoWr", 32'(wrCount - wr0), 32'd0);
        idleCycles(60);

        $display("[TB] timeout");
        wr0 = wrCount;
        tx0 = txCount;
        applyStimulus(8'h57);
        applyStimulus(8'h01);
        idleCycles(50);
        checkOutput("toStillWaiting", 32'(busy), 32'd1);
        idleCycles(100);
        checkOutput("toAborted", 32'(busy), 32'd0);
        checkOutput("toNoResp", 32'(txCount - tx0), 32'd0);
        sendPacket(8'h52, 8'h01, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("toNextRead", 32'(lastTxData), 32'h81);
        checkOutput("toNoWrite", 32'(wrCount - wr0), 32'd0);
        idleCycles(60);

        $display("[TB] pacing and drop");
        sendPacket(8'h52, 8'h03, 8'h00, 1'b0, 8'h00);
        waitIdle();
        prevTx = txCyc;
        sendPacket(8'h52, 8'h05, 8'h00, 1'b0, 8'h00);
        idleCycles(10);
        checkOutput("sendWaiting", 32'(busy), 32'd1);
        applyStimulus(8'h52);
        expDrops++;
        waitIdle();
        checkOutput("paceSpacing", 32'(txCyc - prevTx), 32'd50);
        checkOutput("paceResp", 32'(lastTxData), 32'h85);
        checkOutput("dropCount", 32'(dropCount), 32'd1);
        idleCycles(60);
        sendPacket(8'h52, 8'h02, 8'h00, 1'b0, 8'h00);
        waitIdle();
        checkOutput("afterDropResp", 32'(lastTxData), 32'h82);
        idleCycles(60);

        $display("[TB] reset in GET_DATA");
        tx0 = txCount;
        wr0 = wrCount;
        applyStimulus(8'h57);
        applyStimulus(8'h05);
        @(negedge clk);
        checkOutput("busyInGetData", 32'(busy), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midResetOutputs",
            32'({txValid, txData, regWr, regRd, regAddr, regWdata, busy, drop}), 32'd0);
        rstN = 1'b1;
        idleCycles(20);
        checkOutput("resetIdle", 32'(busy), 32'd0);
        checkOutput("resetNoResp", 32'(txCount - tx0), 32'd0);
        checkOutput("resetNoWrite", 32'(wrCount - wr0), 32'd0);

`ifdef UART_CMD_CSUM_EN
        $display("[TB] checksum");
        sendPacket(8'h57, 8'h02, 8'h11, 1'b1, 8'h44);
        waitIdle();
        checkOutput("csumOkResp", 32'(lastTxData), 32'h4B);
        idleCycles(60);
        wr0 = wrCount;
        sendPacket(8'h57, 8'h02, 8'h11, 1'b1, 8'h00);
        waitIdle();
        checkOutput("csumBadResp", 32'(lastTxData), 32'h45);
        checkOutput("csumBadNoWr", 32'(wrCount - wr0), 32'd0);
        idleCycles(60);
`endif

        idleCycles(5);
        checkOutput("respQueueEmpty", 32'(expResp.size()), 32'd0);
        checkOutput("accQueueEmpty", 32'(expAcc.size()), 32'd0);
        checkOutput("dropTotal", 32'(dropCount), 32'(expDrops));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-facing command responder on the far side of the UART byte interface.
- Consumes received bytes (o_Rx_valid/o_Rx_data of the UART top) and decodes read/write register commands.
- Drives a simple register bus and returns one response byte per command into the UART transmit side (i_Tx_valid/i_Tx_data).

Parameters:
- ADDR_W, 4, register bus address width; valid addresses 0 .. 2^ADDR_W-1.
- TIMEOUT_CYC, 1000000, idle cycles allowed between bytes of one packet before it is aborted.
- TX_GAP_CYC, 11000, minimum cycles between o_tx_valid pulses (one 10-bit frame at 125 MHz / 115200 plus margin).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_rx_valid  in  1  one-cycle strobe, received byte valid.
- i_rx_data  in  8  received byte.
- o_tx_valid  out  1  one-cycle strobe, response byte to transmit.
- o_tx_data  out  8  response byte, held stable until the next strobe.
- o_reg_wr  out  1  one-cycle register write strobe.
- o_reg_rd  out  1  one-cycle register read strobe.
- o_reg_addr  out  ADDR_W  register address.
- o_reg_wdata  out  8  write data.
- i_reg_rdata  in  8  read data, valid exactly 1 cycle after o_reg_rd.
- o_busy  out  1  high outside IDLE.
- o_drop  out  1  one-cycle pulse when a received byte is discarded.

Behaviour:
- Reset (i_rst low, asynchronous):
  - All outputs 0.
  - State IDLE.
  - Timeout and gap counters cleared.
  - Any partial packet discarded, with no response.
- Packet formats:
  - Write: 0x57 'W', addr, data.
  - Read: 0x52 'R', addr.
  - addr byte: bits [ADDR_W-1:0] are used. Any nonzero upper bit is an address error.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: the register byte.
  - Unknown command byte: 0x3F '?'.
  - Address error: 0x45 'E'.
- States:
  - IDLE: on i_rx_valid:
    - 'W' -> GET_ADDR, write flag set.
    - 'R' -> GET_ADDR, write flag clear.
    - Any other byte -> SEND with 0x3F.
  - GET_ADDR: on byte, latch addr.
    - Address error: write -> GET_DATA anyway, so the data byte is consumed; read -> SEND with 0x45.
    - Otherwise: write -> GET_DATA; read -> RD_REQ.
  - GET_DATA: on byte, latch wdata.
    - Address error -> SEND with 0x45.
    - Otherwise -> EXEC.
  - EXEC: o_reg_wr=1 for 1 cycle, response 0x4B -> SEND.
  - RD_REQ: o_reg_rd=1 for 1 cycle -> RD_WAIT.
  - RD_WAIT: capture i_reg_rdata -> SEND.
  - SEND:
    - If the gap counter has expired: o_tx_valid=1 for 1 cycle, o_tx_data=response, reload gap counter with TX_GAP_CYC-1 -> IDLE.
    - Otherwise stay in SEND.
- Gap counter:
  - Free-running down-counter, saturates at 0.
  - Only SEND waits on it; command reception continues while it counts.
- Timeout:
  - In GET_ADDR/GET_DATA, the counter resets on every received byte.
  - If it reaches TIMEOUT_CYC with no byte: back to IDLE, no response, no register access.
- Bytes arriving in EXEC/RD_REQ/RD_WAIT/SEND are discarded, with o_drop pulsed once per byte.
- o_reg_addr/o_reg_wdata hold their last latched values between accesses.
- Latency:
  - Write: o_reg_wr the cycle after EXEC entry; 'K' 1 cycle later, if the gap has expired.
  - Read: data byte 3 cycles after the addr byte strobe, if the gap has expired.
- o_reg_wr and o_reg_rd are never high in the same cycle. Exactly one response per completed packet.

Optional Feature:
- Macro: UART_CMD_CSUM_EN.
- Defined:
  - Every packet carries a trailing checksum byte, the XOR of all preceding packet bytes. It is collected in a GET_CSUM state after GET_ADDR (read) or GET_DATA (write); the timeout also applies there.
  - Mismatch -> 0x45 with no register access. Checksum error takes priority over address error.
  - An unknown command byte is answered immediately with 0x3F, with no checksum expected.
- Not defined: no GET_CSUM state; packets exactly as above.

Test Plan:
- Write: 'W', 0x03, 0xA5 -> o_reg_wr pulse with addr=3, wdata=0xA5; then o_tx_valid with 0x4B.
- Read: 'R', 0x03 with the bench returning 0x5C -> o_reg_rd with addr=3; o_tx_data=0x5C 3 cycles after the addr strobe.
- Errors:
  - 0x41 -> response 0x3F.
  - 'R', 0x20 (ADDR_W=4) -> 0x45, no o_reg_rd.
  - 'W', 0x10, 0x00 -> 0x45, no o_reg_wr.
- Timeout (TIMEOUT_CYC=100): 'W', 0x01, then 150 idle cycles, then 'R', 0x01 -> no write, no response for the first packet; one read response for the second.
- Pacing and drop (TX_GAP_CYC=50):
  - Two back-to-back reads -> o_tx_valid pulses at least 50 cycles apart.
  - A byte injected during SEND -> o_drop pulse, state unaffected.
- Reset and checksum:
  - i_rst low in GET_DATA -> all outputs 0, IDLE, no response.
  - With UART_CMD_CSUM_EN: 'W', 0x02, 0x11, csum=0x44 -> 'K'; csum=0x00 -> 'E', no write.
